// File: rtl/router_fifo.sv
// Per-port router output FIFO: header-tagged byte storage with read-side packet tracking and soft flush.
// Read data and pkt_done are registered one cycle after the accepting edge; writes when full and reads when empty are dropped.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2((2 ** (WIDTH - 2)) + 1);

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CW-1:0]    r_pkt_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_pkt_done;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH:0]   w_rd_ent;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr     = write_enb && !full && !soft_reset;
    assign w_rd     = read_enb && !empty;
    assign w_rd_ent = r_mem[r_rd_ptr[AW-1:0]];
    assign data_out = r_data_out;
    assign pkt_done = r_pkt_done;

    // Storage is never cleared; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
            r_pkt_done <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + (AW + 1)'(1);
                r_data_out <= w_rd_ent[WIDTH-1:0];
                // A header always reloads the count, even mid-packet; +1 covers the parity byte.
                if (w_rd_ent[WIDTH]) begin
                    r_pkt_cnt <= CW'(w_rd_ent[WIDTH-1:2]) + CW'(1);
                end else if (r_pkt_cnt != '0) begin
                    r_pkt_cnt <= r_pkt_cnt - CW'(1);
                    if (r_pkt_cnt == CW'(1)) begin
                        r_pkt_done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: vector table for the packet/flush flows, hand sequences for full, wrap and async reset.
module tb_router_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_done;

    int total = 0;
    int bad   = 0;

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic       lfd;
        logic       sr;
        logic [7:0] din;
        logic [7:0] e_dout;
        logic       e_full;
        logic       e_empty;
        logic       e_done;
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic we, input logic re, input logic lfd, input logic sr,
                        input logic [7:0] din, input logic [7:0] e_dout,
                        input logic e_full, input logic e_empty, input logic e_done);
        tv.push_back('{we, re, lfd, sr, din, e_dout, e_full, e_empty, e_done});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and leave time at 1ns past the edge for sampling.
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic sr,
                       input logic [7:0] din);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        soft_reset = sr;
        data_in    = din;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] d[16];
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int         wr_n;
    logic       we_c;
    logic       re_c;

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(data_out), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        reset = 1'b0;

        // Packet of length 3: header, 3 payload, parity; then read back.
        addv(1, 0, 1, 0, 8'h0C, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h11, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h22, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h33, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h1C, 8'h00, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h0C, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h22, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h33, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h1C, 0, 1, 1);
        addv(0, 0, 0, 0, 8'h00, 8'h1C, 0, 1, 0);
        // Write+read on empty: only the write lands; then a stray byte gives no pulse.
        addv(1, 1, 0, 0, 8'h40, 8'h1C, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h40, 0, 1, 0);
        addv(0, 0, 0, 0, 8'h00, 8'h40, 0, 1, 0);
        // Header length 5, partially read, then flushed by soft_reset with write and read high.
        addv(1, 0, 1, 0, 8'h14, 8'h40, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h01, 8'h40, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h02, 8'h40, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h03, 8'h40, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h14, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h02, 0, 0, 0);
        addv(1, 1, 0, 1, 8'hAA, 8'h00, 0, 1, 0);
        // Four stray bytes after the flush: a stale count would pulse on the fourth.
        addv(1, 0, 0, 0, 8'h05, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h06, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h07, 8'h00, 0, 0, 0);
        addv(1, 0, 0, 0, 8'h08, 8'h00, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h05, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h06, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h07, 0, 0, 0);
        addv(0, 1, 0, 0, 8'h00, 8'h08, 0, 1, 0);
        addv(0, 0, 0, 0, 8'h00, 8'h08, 0, 1, 0);

        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].we, tv[i].re, tv[i].lfd, tv[i].sr, tv[i].din);
            chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(tv[i].e_dout));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].e_full));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].e_empty));
            chk($sformatf("v%0d_done", i), 32'(pkt_done), 32'(tv[i].e_done));
        end

        // Fill to 16, drop a 17th write, drain in order.
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'(i * 17 + 3);
            cyc(1, 0, 0, 0, d[i]);
            chk($sformatf("fill%0d_full", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
        end
        cyc(1, 0, 0, 0, 8'hFF);
        chk("over_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'(d[i]));
            chk($sformatf("drain%0d_empty", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("drain_full", 32'(full), 32'd0);

        // Full FIFO with simultaneous write and read: read wins, write is lost.
        for (int i = 0; i < 16; i++) begin
            d[i] = ~8'(i * 17 + 3);
            cyc(1, 0, 0, 0, d[i]);
        end
        chk("refill_full", 32'(full), 32'd1);
        cyc(1, 1, 0, 0, 8'hEE);
        chk("fullrw_dout", 32'(data_out), 32'(d[0]));
        chk("fullrw_full", 32'(full), 32'd0);
        chk("fullrw_empty", 32'(empty), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 1, 0, 0, 8'h00);
            chk($sformatf("fullrw_drain%0d", i), 32'(data_out), 32'(d[i]));
        end
        chk("fullrw_end_empty", 32'(empty), 32'd1);
        chk("fullrw_end_done", 32'(pkt_done), 32'd0);

        // Interleaved traffic across pointer wrap, occupancy held within 1..15 until the final drain.
        wr_n = 0;
        for (int i = 0; i < 150 && (wr_n < 40 || q.size() > 0); i++) begin
            we_c = (wr_n < 40) && (q.size() < 15) && (i % 3 != 1);
            re_c = (q.size() > 1) || ((wr_n == 40) && (q.size() > 0));
            exp_b = 8'h00;
            if (re_c) exp_b = q.pop_front();
            cyc(we_c, re_c, 0, 0, 8'(wr_n * 5 + 9));
            if (we_c) begin
                q.push_back(8'(wr_n * 5 + 9));
                wr_n++;
            end
            if (re_c) chk($sformatf("wrap%0d_dout", i), 32'(data_out), 32'(exp_b));
            chk($sformatf("wrap%0d_empty", i), 32'(empty), (q.size() == 0) ? 32'd1 : 32'd0);
            chk($sformatf("wrap%0d_fe", i), 32'(full && empty), 32'd0);
        end

        // Asynchronous reset between edges, mid-packet.
        cyc(1, 0, 1, 0, 8'h10);
        cyc(1, 0, 0, 0, 8'h55);
        cyc(0, 1, 0, 0, 8'h00);
        chk("ar_pre_dout", 32'(data_out), 32'h10);
        cyc(0, 0, 0, 0, 8'h00);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_dout", 32'(data_out), 32'h00);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        #1;
        reset = 1'b0;
        cyc(1, 0, 1, 0, 8'h08);
        chk("ar_post_empty", 32'(empty), 32'd0);
        cyc(0, 1, 0, 0, 8'h00);
        chk("ar_post_dout", 32'(data_out), 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO for the 1x3 router. It sits directly downstream of the register/parity stage: it accepts one byte per write from that stage, tagged with the header-load flag, and presents bytes to the destination reader. It tracks packet boundaries on the read side using the length field of each header. It also supports a synchronous soft reset that flushes a packet the reader abandoned.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 4
- WIDTH, 8, data byte width; header length field is data[WIDTH-1:2]

Ports:
- clk, in, 1, single clock; all state updates on its rising edge
- reset, in, 1, asynchronous, active-high reset
- soft_reset, in, 1, synchronous flush; when high at a rising edge, it acts as reset for all state
- write_enb, in, 1, write request from the register stage
- read_enb, in, 1, read request from the destination
- lfd_state, in, 1, marks the byte being written as a header; stored as entry bit WIDTH
- data_in, in, WIDTH, byte to store
- data_out, out, WIDTH, registered read data
- full, out, 1, combinational; no free entry
- empty, out, 1, combinational; no stored entry
- pkt_done, out, 1, registered; one-cycle pulse when the last byte of a packet is read

## Operation
- Storage: DEPTH entries, each WIDTH+1 bits wide: the header flag plus the byte.
- Pointers: wr_ptr and rd_ptr, each clog2(DEPTH)+1 bits.
  - empty when the pointers are equal.
  - full when the MSBs differ and all lower bits are equal.
- Write is accepted when write_enb is high and full is low.
  - Stores {lfd_state, data_in} at wr_ptr and increments wr_ptr (wraps naturally).
  - When full is high, the write is dropped silently and no state changes.
- Read is accepted when read_enb is high and empty is low.
  - Loads data_out with the stored byte and increments rd_ptr.
  - When empty is high, the read is ignored and data_out holds its value.
- Read-side packet counter pkt_cnt is clog2 of (2^(WIDTH-2)+1) bits wide (7 bits at WIDTH=8).
  - Read of a flagged entry: pkt_cnt <= byte[WIDTH-1:2] + 1, covering payload bytes plus the parity byte. This happens even if a packet is in progress, so a new header overrides the old count.
  - Read of an unflagged entry with pkt_cnt > 0: pkt_cnt decrements. pkt_done pulses on the following cycle when pkt_cnt goes from 1 to 0.
  - Read of an unflagged entry with pkt_cnt == 0 (stray byte): the byte is still output, pkt_cnt stays 0, and there is no pulse.
- Simultaneous write and read:
  - Non-full, non-empty: both happen and occupancy is unchanged.
  - Empty: only the write happens.
  - Full: only the read happens; full drops next cycle and the write is lost.
- Priority per edge: reset > soft_reset > read/write.
- Reset and soft_reset values:
  - wr_ptr, rd_ptr, pkt_cnt: 0
  - data_out: 0
  - pkt_done: 0
  - hence empty=1, full=0
  - Storage contents are not cleared.

## Timing
- Write-to-empty-deasserted: 1 cycle; empty falls on the edge that accepts the first write.
- Read latency: data_out is valid 1 cycle after the accepting edge and holds until the next accepted read.
- full and empty change only on clock edges, because they derive from registered pointers.
- pkt_done is high for exactly the one cycle after the edge that read the final byte.
- reset takes effect immediately, independent of clk. Deassertion is synchronous to design use; data is accepted from the first edge after release.
- A soft_reset asserted in the same cycle as write_enb and read_enb discards both requests.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset, then write header 0x0C (length 3, lfd_state=1), then 0x11, 0x22, 0x33, then parity 0x1C; read 5 times.
  - Required: data_out = 0x0C, 0x11, 0x22, 0x33, 0x1C on consecutive cycles.
  - pkt_done pulses once, the cycle after the fifth read; empty=1 afterwards.
- Write 16 bytes with no reads.
  - Required: full=1 after the 16th edge.
  - A 17th write of 0xFF is dropped; reading 16 entries returns the original 16 bytes in order, and empty=1.
- Full FIFO with write_enb and read_enb high in the same cycle.
  - Required: the oldest byte is read, the write is dropped, and occupancy goes to 15 (full=0, empty=0).
- Empty FIFO with write_enb and read_enb high and data_in 0x40.
  - Required: the write is stored, data_out is unchanged, and empty=0 next cycle.
- Packet half-read: header 0x14 (length 5), 2 bytes read, then soft_reset pulsed with write_enb high.
  - Required: empty=1, data_out=0x00, pkt_cnt=0, and no pkt_done pulse.
- Wrap-around: 40 interleaved writes/reads with occupancy kept between 1 and 15.
  - Required: every byte is read out in order; full and empty are never both high.
- Asynchronous reset mid-packet, asserted between clock edges.
  - Required: data_out=0, empty=1, full=0 immediately, before the next edge.
